// File: rtl/uart_pkg.sv
// Shared definitions for the UART core: engine state encodings, oversampling ratio
// and the parity helper used by both the RX and TX engines.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // Data is zero-extended by the caller, so frames of up to 16 bits are covered.
  function automatic logic parity_of(input logic [15:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO with valid/ready on both sides; pointers carry an
// extra wrap bit so full and empty are told apart without a separate counter.
module uart_sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         wr_valid_i,
  input  logic [W-1:0] wr_data_i,
  output logic         wr_ready_o,
  output logic         rd_valid_o,
  output logic [W-1:0] rd_data_o,
  input  logic         rd_ready_i
);

  localparam int            DEPTH   = 1 << AW;
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         full_s;
  logic         empty_s;
  logic         push_s;
  logic         pop_s;

  always_comb begin
    full_s     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty_s    = (wr_ptr_q == rd_ptr_q);
    push_s     = wr_valid_i & ~full_s;
    pop_s      = rd_ready_i & ~empty_s;
    wr_ready_o = ~full_s;
    rd_valid_o = ~empty_s;
    rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Storage is cleared on reset so the show-ahead head reads 0 while empty after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        wr_ptr_q                <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/uart_fifo_core.sv
// UART core: programmable x16 baud tick, RX/TX engines with optional parity and
// TX/RX FIFOs behind valid/ready ports, plus sticky overrun/framing/parity flags.
module uart_fifo_core #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_AW    = 4,
  parameter int DIV_W      = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [DIV_W-1:0] i_div,
  input  logic [DBIT-1:0]  i_tx_data,
  input  logic             i_tx_valid,
  output logic             o_tx_ready,
  output logic [DBIT-1:0]  o_rx_data,
  output logic             o_rx_valid,
  input  logic             i_rx_ready,
  input  logic             i_rx,
  output logic             o_tx,
  output logic             o_tx_busy,
  input  logic             i_err_clr,
  output logic             o_rx_overrun,
  output logic             o_rx_frame_err,
  output logic             o_rx_parity_err
);

  import uart_pkg::*;

  localparam int TW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [TW-1:0]    T_ONE   = TW'(1);
  localparam logic [TW-1:0]    T_MID   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]    T_BIT   = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0]    T_STOP  = TW'(SB_TICK - 1);
  localparam logic [NW-1:0]    N_ONE   = NW'(1);
  localparam logic [NW-1:0]    N_LAST  = NW'(DBIT - 1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic             PAR_ODD = (PARITY_ODD != 0);

  logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d, div_last_s;
  logic             tick_s;
  logic [1:0]       sync_q;
  logic             rx_sync_s;

  rx_state_e        rx_state_q, rx_state_d;
  logic [TW-1:0]    rx_tick_q, rx_tick_d;
  logic [NW-1:0]    rx_bit_q, rx_bit_d;
  logic [DBIT-1:0]  rx_shift_q, rx_shift_d;
  logic             rx_done_s, rx_par_bad_s, rx_fifo_ready_s;

  tx_state_e        tx_state_q, tx_state_d;
  logic [TW-1:0]    tx_tick_q, tx_tick_d;
  logic [NW-1:0]    tx_bit_q, tx_bit_d;
  logic [DBIT-1:0]  tx_shift_q, tx_shift_d;
  logic             tx_par_q, tx_par_d;
  logic             tx_out_q, tx_out_d;
  logic             tx_pop_s, tx_has_s;
  logic [DBIT-1:0]  tx_head_s;

  logic             ovr_q, ovr_d, fe_q, fe_d, pe_q, pe_d;

  // A divisor of 0 behaves as 1; the >= compare lets a shrunken divisor wrap at once.
  always_comb begin
    div_last_s = (i_div == '0) ? '0 : i_div - DIV_ONE;
    tick_s     = (tick_cnt_q >= div_last_s);
    tick_cnt_d = tick_s ? '0 : tick_cnt_q + DIV_ONE;
  end

  assign rx_sync_s = sync_q[1];

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_tick_d    = rx_tick_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_done_s    = 1'b0;
    rx_par_bad_s = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_s) begin
          rx_state_d = RX_START;
          rx_tick_d  = '0;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (tick_s && rx_tick_q == T_MID) begin
          rx_state_d = rx_sync_s ? RX_IDLE : RX_DATA;
          rx_tick_d  = '0;
          rx_bit_d   = '0;
        end else if (tick_s) begin
          rx_tick_d = rx_tick_q + T_ONE;
        end else begin
          rx_tick_d = rx_tick_q;
        end
      end
      RX_DATA: begin
        if (tick_s && rx_tick_q == T_BIT) begin
          rx_tick_d  = '0;
          rx_shift_d = {rx_sync_s, rx_shift_q[DBIT-1:1]};
          if (rx_bit_q == N_LAST) begin
            rx_state_d = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + N_ONE;
          end
        end else if (tick_s) begin
          rx_tick_d = rx_tick_q + T_ONE;
        end else begin
          rx_tick_d = rx_tick_q;
        end
      end
      RX_PARITY: begin
        if (tick_s && rx_tick_q == T_BIT) begin
          rx_tick_d    = '0;
          rx_state_d   = RX_STOP;
          rx_par_bad_s = (rx_sync_s != parity_of(16'(rx_shift_q), PAR_ODD));
        end else if (tick_s) begin
          rx_tick_d = rx_tick_q + T_ONE;
        end else begin
          rx_tick_d = rx_tick_q;
        end
      end
      RX_STOP: begin
        if (tick_s && rx_tick_q == T_STOP) begin
          rx_done_s  = 1'b1;
          rx_state_d = RX_IDLE;
        end else if (tick_s) begin
          rx_tick_d = rx_tick_q + T_ONE;
        end else begin
          rx_tick_d = rx_tick_q;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // o_tx is set on the transition into each segment so every bit lasts exactly 16 ticks.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_out_d   = tx_out_q;
    tx_pop_s   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_out_d = 1'b1;
        if (tick_s && tx_has_s) begin
          tx_pop_s   = 1'b1;
          tx_shift_d = tx_head_s;
          tx_par_d   = parity_of(16'(tx_head_s), PAR_ODD);
          tx_state_d = TX_START;
          tx_tick_d  = '0;
          tx_out_d   = 1'b0;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (tick_s && tx_tick_q == T_BIT) begin
          tx_state_d = TX_DATA;
          tx_tick_d  = '0;
          tx_bit_d   = '0;
          tx_out_d   = tx_shift_q[0];
        end else if (tick_s) begin
          tx_tick_d = tx_tick_q + T_ONE;
        end else begin
          tx_tick_d = tx_tick_q;
        end
      end
      TX_DATA: begin
        if (tick_s && tx_tick_q == T_BIT) begin
          tx_tick_d  = '0;
          tx_shift_d = {1'b0, tx_shift_q[DBIT-1:1]};
          if (tx_bit_q == N_LAST) begin
            tx_state_d = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
            tx_out_d   = (PARITY_EN != 0) ? tx_par_q : 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + N_ONE;
            tx_out_d = tx_shift_q[1];
          end
        end else if (tick_s) begin
          tx_tick_d = tx_tick_q + T_ONE;
        end else begin
          tx_tick_d = tx_tick_q;
        end
      end
      TX_PARITY: begin
        if (tick_s && tx_tick_q == T_BIT) begin
          tx_state_d = TX_STOP;
          tx_tick_d  = '0;
          tx_out_d   = 1'b1;
        end else if (tick_s) begin
          tx_tick_d = tx_tick_q + T_ONE;
        end else begin
          tx_tick_d = tx_tick_q;
        end
      end
      TX_STOP: begin
        // Chain straight into the next start bit so queued bytes leave no gap.
        if (tick_s && tx_tick_q == T_STOP && tx_has_s) begin
          tx_pop_s   = 1'b1;
          tx_shift_d = tx_head_s;
          tx_par_d   = parity_of(16'(tx_head_s), PAR_ODD);
          tx_state_d = TX_START;
          tx_tick_d  = '0;
          tx_out_d   = 1'b0;
        end else if (tick_s && tx_tick_q == T_STOP) begin
          tx_state_d = TX_IDLE;
          tx_out_d   = 1'b1;
        end else if (tick_s) begin
          tx_tick_d = tx_tick_q + T_ONE;
        end else begin
          tx_tick_d = tx_tick_q;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_out_d   = 1'b1;
      end
    endcase
  end

  always_comb begin
    ovr_d = (rx_done_s & ~rx_fifo_ready_s) | (ovr_q & ~i_err_clr);
    fe_d  = (rx_done_s & ~rx_sync_s)       | (fe_q  & ~i_err_clr);
    pe_d  = rx_par_bad_s                   | (pe_q  & ~i_err_clr);
  end

  // All state registers; the synchroniser presets to idle-high so reset never looks like a start bit.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      tick_cnt_q <= '0;
      sync_q     <= 2'b11;
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_out_q   <= 1'b1;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      sync_q     <= {sync_q[0], i_rx};
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_out_q   <= tx_out_d;
      ovr_q      <= ovr_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
    end
  end

  uart_sync_fifo #(.W(DBIT), .AW(FIFO_AW)) u_tx_fifo (
    .clk_i      (i_clock),
    .rst_i      (i_reset),
    .wr_valid_i (i_tx_valid),
    .wr_data_i  (i_tx_data),
    .wr_ready_o (o_tx_ready),
    .rd_valid_o (tx_has_s),
    .rd_data_o  (tx_head_s),
    .rd_ready_i (tx_pop_s)
  );

  uart_sync_fifo #(.W(DBIT), .AW(FIFO_AW)) u_rx_fifo (
    .clk_i      (i_clock),
    .rst_i      (i_reset),
    .wr_valid_i (rx_done_s),
    .wr_data_i  (rx_shift_q),
    .wr_ready_o (rx_fifo_ready_s),
    .rd_valid_o (o_rx_valid),
    .rd_data_o  (o_rx_data),
    .rd_ready_i (i_rx_ready)
  );

  assign o_tx            = tx_out_q;
  assign o_tx_busy       = (tx_state_q != TX_IDLE) | tx_has_s;
  assign o_rx_overrun    = ovr_q;
  assign o_rx_frame_err  = fe_q;
  assign o_rx_parity_err = pe_q;

endmodule

// File: tb/tb_uart_fifo_core.sv
// Scoreboard bench: dut_a (no parity) covers TX timing, loopback, errors, overrun and
// reset; dut_b (even parity) covers parity checking. Expected RX bytes are queued at stimulus time.
module tb_uart_fifo_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] div;

  logic [7:0]  a_tx_data, a_rx_data, b_tx_data, b_rx_data;
  logic        a_tx_valid, a_tx_ready, a_rx_valid, a_rx_ready, a_tx, a_busy, a_clr;
  logic        a_ovr, a_fe, a_pe, a_rx_in;
  logic        b_tx_valid, b_tx_ready, b_rx_valid, b_rx_ready, b_tx, b_busy, b_clr;
  logic        b_ovr, b_fe, b_pe, b_rx_in;
  logic        drv_a, drv_b, loop_a;

  logic [7:0]  exp_a[$];
  logic [7:0]  exp_b[$];
  int          n_checks = 0;
  int          n_errs   = 0;
  int          a_pops   = 0;
  int          b_pops   = 0;

  always #5 clk = ~clk;

  assign a_rx_in = loop_a ? a_tx : drv_a;
  assign b_rx_in = drv_b;

  uart_fifo_core #(.PARITY_EN(0)) dut_a (
    .i_clock(clk), .i_reset(rst), .i_div(div),
    .i_tx_data(a_tx_data), .i_tx_valid(a_tx_valid), .o_tx_ready(a_tx_ready),
    .o_rx_data(a_rx_data), .o_rx_valid(a_rx_valid), .i_rx_ready(a_rx_ready),
    .i_rx(a_rx_in), .o_tx(a_tx), .o_tx_busy(a_busy), .i_err_clr(a_clr),
    .o_rx_overrun(a_ovr), .o_rx_frame_err(a_fe), .o_rx_parity_err(a_pe)
  );

  uart_fifo_core #(.PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_div(div),
    .i_tx_data(b_tx_data), .i_tx_valid(b_tx_valid), .o_tx_ready(b_tx_ready),
    .o_rx_data(b_rx_data), .o_rx_valid(b_rx_valid), .i_rx_ready(b_rx_ready),
    .i_rx(b_rx_in), .o_tx(b_tx), .o_tx_busy(b_busy), .i_err_clr(b_clr),
    .o_rx_overrun(b_ovr), .o_rx_frame_err(b_fe), .o_rx_parity_err(b_pe)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Compare every consumed RX byte against the scoreboard; 0x100 marks a byte nobody expected.
  always @(negedge clk) begin
    if (!rst && a_rx_valid && a_rx_ready) begin
      a_pops++;
      if (exp_a.size() == 0) check_eq("rxa_unexpected", {24'd0, a_rx_data}, 32'h100);
      else check_eq("rxa_data", {24'd0, a_rx_data}, {24'd0, exp_a.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!rst && b_rx_valid && b_rx_ready) begin
      b_pops++;
      if (exp_b.size() == 0) check_eq("rxb_unexpected", {24'd0, b_rx_data}, 32'h100);
      else check_eq("rxb_data", {24'd0, b_rx_data}, {24'd0, exp_b.pop_front()});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) drv_b = v;
    else drv_a = v;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en, input logic par,
                            input logic stop_val, input int stop_clks);
    set_rx(sel, 1'b0);
    wait_clks(64);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, d[i]);
      wait_clks(64);
    end
    if (par_en) begin
      set_rx(sel, par);
      wait_clks(64);
    end
    set_rx(sel, stop_val);
    wait_clks(stop_clks);
    set_rx(sel, 1'b1);
    wait_clks(64);
  endtask

  task automatic drain(input bit sel, input int budget);
    int k = 0;
    while (((sel ? exp_b.size() : exp_a.size()) != 0) && k < budget) begin
      wait_clks(1);
      k++;
    end
    check_eq(sel ? "drain_b" : "drain_a", sel ? exp_b.size() : exp_a.size(), 0);
  endtask

  initial begin
    logic [7:0] pat;
    int         k, pops_before, acc;
    logic       hs;

    rst = 1'b1; div = 16'd4;
    a_tx_data = 8'h00; a_tx_valid = 1'b0; a_rx_ready = 1'b1; a_clr = 1'b0;
    b_tx_data = 8'h00; b_tx_valid = 1'b0; b_rx_ready = 1'b1; b_clr = 1'b0;
    drv_a = 1'b1; drv_b = 1'b1; loop_a = 1'b0;
    wait_clks(3);
    check_eq("rst_tx", a_tx, 1);
    check_eq("rst_tx_ready", a_tx_ready, 1);
    check_eq("rst_rx_valid", a_rx_valid, 0);
    check_eq("rst_busy", a_busy, 0);
    check_eq("rst_rx_data", a_rx_data, 0);
    check_eq("rst_flags", {a_ovr, a_fe, a_pe}, 0);
    rst = 1'b0;
    wait_clks(5);

    // TX waveform of 0xA5: 64-clock start bit, data LSB first, stop, then idle.
    pat = 8'hA5;
    a_tx_data = pat; a_tx_valid = 1'b1;
    wait_clks(1);
    a_tx_valid = 1'b0;
    check_eq("t1_busy_after_push", a_busy, 1);
    k = 0;
    while (a_tx !== 1'b0 && k < 100) begin
      wait_clks(1);
      k++;
    end
    check_eq("t1_start_seen", a_tx, 0);
    wait_clks(63);
    check_eq("t1_start_len", a_tx, 0);
    wait_clks(1);
    check_eq("t1_bit0_edge", a_tx, {31'd0, pat[0]});
    wait_clks(32);
    for (int j = 0; j < 8; j++) begin
      check_eq($sformatf("t1_bit%0d", j), a_tx, {31'd0, pat[j]});
      wait_clks(64);
    end
    check_eq("t1_stop", a_tx, 1);
    wait_clks(31);
    check_eq("t1_busy_in_stop", a_busy, 1);
    wait_clks(2);
    check_eq("t1_busy_done", a_busy, 0);
    check_eq("t1_idle_high", a_tx, 1);

    // Loopback of three back-to-back bytes.
    loop_a = 1'b1;
    a_tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: a_tx_data = 8'h00;
        1: a_tx_data = 8'hFF;
        default: a_tx_data = 8'h3C;
      endcase
      if (a_tx_ready) exp_a.push_back(a_tx_data);
      wait_clks(1);
    end
    a_tx_valid = 1'b0;
    drain(1'b0, 3000);
    check_eq("t2_pops", a_pops, 3);
    check_eq("t2_flags", {a_ovr, a_fe, a_pe}, 0);
    wait_clks(100);
    loop_a = 1'b0;

    // Even parity: 0x01 with parity 0 is a mismatch, 0x03 with parity 0 is correct.
    exp_b.push_back(8'h01);
    send_frame(1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 64);
    drain(1'b1, 500);
    check_eq("t3_parity_err", b_pe, 1);
    check_eq("t3_no_frame_err", b_fe, 0);
    b_clr = 1'b1;
    wait_clks(1);
    b_clr = 1'b0;
    check_eq("t3_parity_clr", b_pe, 0);
    exp_b.push_back(8'h03);
    send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 64);
    drain(1'b1, 500);
    check_eq("t3_parity_ok", b_pe, 0);

    // Framing error still delivers the byte; a short glitch delivers nothing.
    exp_a.push_back(8'h5A);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 40);
    drain(1'b0, 500);
    check_eq("t4_frame_err", a_fe, 1);
    check_eq("t4_no_overrun", a_ovr, 0);
    pops_before = a_pops;
    drv_a = 1'b0;
    wait_clks(3);
    drv_a = 1'b1;
    wait_clks(200);
    check_eq("t4_glitch_valid", a_rx_valid, 0);
    check_eq("t4_glitch_pops", a_pops, pops_before);
    a_clr = 1'b1;
    wait_clks(1);
    a_clr = 1'b0;
    check_eq("t4_clr", {a_ovr, a_fe, a_pe}, 0);

    // Seventeen frames into a 16-entry RX FIFO with the consumer stalled.
    a_rx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      pat = 8'(i * 13 + 5);
      if (i < 16) exp_a.push_back(pat);
      send_frame(1'b0, pat, 1'b0, 1'b0, 1'b1, 64);
    end
    check_eq("t5_overrun", a_ovr, 1);
    check_eq("t5_valid", a_rx_valid, 1);
    check_eq("t5_head", a_rx_data, {24'd0, exp_a[0]});
    a_rx_ready = 1'b1;
    drain(1'b0, 100);
    wait_clks(2);
    check_eq("t5_empty", a_rx_valid, 0);
    check_eq("t5_no_frame_err", a_fe, 0);

    // TX FIFO fill: the engine takes one byte, so 17 are accepted before the FIFO is full.
    acc = 0;
    a_tx_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      a_tx_data = 8'(acc);
      hs = a_tx_ready;
      wait_clks(1);
      if (hs) acc++;
    end
    a_tx_valid = 1'b0;
    check_eq("t6_accepted", acc, 17);
    check_eq("t6_full", a_tx_ready, 0);
    wait_clks(100);
    check_eq("t6_mid_frame_low", a_tx, 0);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_tx", a_tx, 1);
    check_eq("t6_rst_busy", a_busy, 0);
    check_eq("t6_rst_ready", a_tx_ready, 1);
    wait_clks(2);
    rst = 1'b0;
    wait_clks(200);
    check_eq("t6_after_rst_tx", a_tx, 1);
    check_eq("t6_after_rst_busy", a_busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
